// File: rtl/cmp_pkg.sv
// Shared definitions for the min/max sequencer: state encoding,
// comparator result bit positions and default widths.
package cmp_pkg;

    localparam int W_DEF     = 4;
    localparam int CNT_W_DEF = 4;

    // Comparator result bit positions (exactly one bit is set).
    localparam int GT_BIT = 2;
    localparam int EQ_BIT = 1;
    localparam int LT_BIT = 0;

    // State encodings.
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_CMP_MAX = 3'd2;
    localparam logic [2:0] S_CMP_MIN = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_WAIT    = S_WAIT,
        ST_CMP_MAX = S_CMP_MAX,
        ST_CMP_MIN = S_CMP_MIN,
        ST_DONE    = S_DONE
    } state_t;

endpackage

// File: rtl/cmp_mag.sv
// Combinational W-bit unsigned magnitude comparator: y = {a>b, a==b, a<b}.
module cmp_mag
    import cmp_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [2:0]   y
);

    // One-hot compare result; exactly one branch fires.
    always_comb begin
        y = 3'b000;
        if (a > b) begin
            y[GT_BIT] = 1'b1;
        end else if (a == b) begin
            y[EQ_BIT] = 1'b1;
        end else begin
            y[LT_BIT] = 1'b1;
        end
    end

endmodule

// File: rtl/cmp_minmax_seq.sv
// Burst min/max finder: one shared comparator is used twice per sample,
// first against the running max, then against the running min.
module cmp_minmax_seq
    import cmp_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     max_val,
    output logic [W-1:0]     min_val,
    output logic [CNT_W-1:0] max_idx,
    output logic [CNT_W-1:0] max_cnt
);

    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]     DZERO_C = {W{1'b0}};

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] len_r;
    logic [CNT_W-1:0] idx_r;
    logic [W-1:0]     operand_r;
    logic [W-1:0]     max_val_r;
    logic [W-1:0]     min_val_r;
    logic [CNT_W-1:0] max_idx_r;
    logic [CNT_W-1:0] max_cnt_r;
    logic             in_ready_r;
    logic             busy_r;
    logic             done_r;
    logic [W-1:0]     cmp_b_s;
    logic [2:0]       cmp_y_s;
    logic             xfer_s;
    logic             last_s;

    // in_ready_r is high exactly while in WAIT, so this is the handshake.
    assign xfer_s = in_valid & in_ready_r;
    assign last_s = (idx_r == (len_r - ONE_C));

    // Comparator B operand follows the compare phase; A is always the sample.
    always_comb begin
        cmp_b_s = max_val_r;
        case (state_r)
            ST_CMP_MIN: cmp_b_s = min_val_r;
            default:    cmp_b_s = max_val_r;
        endcase
    end

    cmp_mag #(.W(W)) u_cmp (
        .a (operand_r),
        .b (cmp_b_s),
        .y (cmp_y_s)
    );

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len != ZERO_C) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (xfer_s) begin
                    if (idx_r != ZERO_C) begin
                        state_s = ST_CMP_MAX;
                    end else if (last_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_CMP_MAX: state_s = ST_CMP_MIN;
            ST_CMP_MIN: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Handshake/status outputs registered from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            in_ready_r <= (state_s == ST_WAIT);
            busy_r     <= (state_s == ST_WAIT) || (state_s == ST_CMP_MAX) ||
                          (state_s == ST_CMP_MIN);
            done_r     <= (state_s == ST_DONE);
        end
    end

    // Burst datapath: length/index counters, operand and running results.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_r     <= ZERO_C;
            idx_r     <= ZERO_C;
            operand_r <= DZERO_C;
            max_val_r <= DZERO_C;
            min_val_r <= DZERO_C;
            max_idx_r <= ZERO_C;
            max_cnt_r <= ZERO_C;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        len_r     <= len;
                        idx_r     <= ZERO_C;
                        operand_r <= DZERO_C;
                        max_val_r <= DZERO_C;
                        min_val_r <= DZERO_C;
                        max_idx_r <= ZERO_C;
                        max_cnt_r <= ZERO_C;
                    end
                end
                ST_WAIT: begin
                    if (xfer_s) begin
                        operand_r <= in_data;
                        if (idx_r == ZERO_C) begin
                            // First sample seeds both extremes without comparing.
                            max_val_r <= in_data;
                            min_val_r <= in_data;
                            max_idx_r <= ZERO_C;
                            max_cnt_r <= ONE_C;
                            if (!last_s) begin
                                idx_r <= idx_r + ONE_C;
                            end
                        end
                    end
                end
                ST_CMP_MAX: begin
                    if (cmp_y_s[GT_BIT]) begin
                        max_val_r <= operand_r;
                        max_idx_r <= idx_r;
                        max_cnt_r <= ONE_C;
                    end else if (cmp_y_s[EQ_BIT]) begin
                        max_cnt_r <= max_cnt_r + ONE_C;
                    end
                end
                ST_CMP_MIN: begin
                    // Strict less-than only, so ties keep the current min.
                    if (cmp_y_s[LT_BIT]) begin
                        min_val_r <= operand_r;
                    end
                    if (!last_s) begin
                        idx_r <= idx_r + ONE_C;
                    end
                end
                default: begin
                    len_r <= len_r;
                end
            endcase
        end
    end

    assign in_ready = in_ready_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign max_val  = max_val_r;
    assign min_val  = min_val_r;
    assign max_idx  = max_idx_r;
    assign max_cnt  = max_cnt_r;

endmodule

// File: tb/tb_cmp_minmax_seq.sv
// Scoreboard bench for cmp_minmax_seq: stimulus pushes hand-computed
// results, a negedge monitor pops and checks them when done pulses.
module tb_cmp_minmax_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] len = 4'd0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [3:0] max_val;
    logic [3:0] min_val;
    logic [3:0] max_idx;
    logic [3:0] max_cnt;

    typedef struct {
        int n;
        int mx;
        int mn;
        int idx;
        int cnt;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    logic [3:0] smp [0:15];

    always #5 clk = ~clk;

    cmp_minmax_seq dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .busy(busy), .done(done), .max_val(max_val), .min_val(min_val),
        .max_idx(max_idx), .max_cnt(max_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: tracks transfers/latency, pops expectations on done.
    int  ncyc = 0;
    int  last_evt = 0;
    int  xfer_cnt = 0;
    int  cmp_hold = 0;
    bit  prev_done = 1'b0;
    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            xfer_cnt  = 0;
            cmp_hold  = 0;
            prev_done = 1'b0;
        end else begin
            if (start && !busy && !done) begin
                last_evt = ncyc;
                xfer_cnt = 0;
            end
            if (cmp_hold > 0) begin
                chk("ready_in_cmp", int'(in_ready), 0);
                cmp_hold--;
            end
            if (in_valid && in_ready) begin
                xfer_cnt++;
                last_evt = ncyc;
                if (xfer_cnt > 1) cmp_hold = 2;
            end
            if (done) begin
                exp_t e;
                done_cnt++;
                if (prev_done) chk("done_width", 2, 1);
                if (q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("max_val", int'(max_val), e.mx);
                    chk("min_val", int'(min_val), e.mn);
                    chk("max_idx", int'(max_idx), e.idx);
                    chk("max_cnt", int'(max_cnt), e.cnt);
                    chk("transfers", xfer_cnt, e.n);
                    chk("done_latency", ncyc - last_evt, (e.n <= 1) ? 1 : 3);
                end
            end
            prev_done = done;
        end
    end

    task automatic push_exp(input int n, input int mx, input int mn,
                            input int idx, input int cnt);
        exp_t e;
        e.n = n; e.mx = mx; e.mn = mn; e.idx = idx; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        len   = 4'(n);
        @(posedge clk); #1;
        start = 1'b0;
        len   = 4'd0;
    endtask

    task automatic send_one(input logic [3:0] d, input bit rnd);
        bit got = 1'b0;
        int guard = 0;
        in_data = d;
        while (!got && guard < 100) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            got = in_valid && in_ready;
            @(posedge clk); #1;
            guard++;
        end
        if (!got) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_done(input int target);
        int guard = 0;
        while (done_cnt < target && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("done_seen", done_cnt, target);
    endtask

    task automatic run_burst(input int n, input bit rnd);
        int target;
        target = done_cnt + 1;
        do_start(n);
        for (int i = 0; i < n; i++) send_one(smp[i], rnd);
        in_valid = 1'b0;
        wait_done(target);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_busy"},     int'(busy), 0);
        chk({tag, "_done"},     int'(done), 0);
        chk({tag, "_max_val"},  int'(max_val), 0);
        chk({tag, "_min_val"},  int'(min_val), 0);
        chk({tag, "_max_idx"},  int'(max_idx), 0);
        chk({tag, "_max_cnt"},  int'(max_cnt), 0);
    endtask

    initial begin
        int snap;
        // Power-on reset.
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset mid-burst: no done, everything cleared.
        do_start(3);
        send_one(4'd5, 1'b0);
        in_valid = 1'b0;
        chk("midburst_busy", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_zero("abort");
        snap = done_cnt;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, snap);

        // Basic burst 3,9,1,9.
        smp[0] = 4'd3; smp[1] = 4'd9; smp[2] = 4'd1; smp[3] = 4'd9;
        push_exp(4, 9, 1, 1, 2);
        run_burst(4, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_max_val", int'(max_val), 9);
        chk("hold_min_val", int'(min_val), 1);

        // Single sample.
        smp[0] = 4'd7;
        push_exp(1, 7, 7, 0, 1);
        run_burst(1, 1'b0);

        // len = 0 with in_valid held high: no transfers allowed.
        push_exp(0, 0, 0, 0, 0);
        in_valid = 1'b1;
        in_data  = 4'd11;
        snap = done_cnt + 1;
        do_start(0);
        wait_done(snap);
        in_valid = 1'b0;

        // Back-pressure with random in_valid.
        smp[0] = 4'd15; smp[1] = 4'd0; smp[2] = 4'd15;
        push_exp(3, 15, 0, 0, 2);
        run_burst(3, 1'b1);

        // start pulsed while busy must be ignored.
        push_exp(3, 6, 2, 2, 1);
        snap = done_cnt + 1;
        do_start(3);
        send_one(4'd4, 1'b0);
        in_valid = 1'b0;
        start = 1'b1;
        len   = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        len   = 4'd0;
        send_one(4'd2, 1'b0);
        send_one(4'd6, 1'b0);
        in_valid = 1'b0;
        wait_done(snap);

        // Ties on both extremes.
        smp[0] = 4'd8; smp[1] = 4'd3; smp[2] = 4'd8; smp[3] = 4'd2; smp[4] = 4'd3;
        push_exp(5, 8, 2, 0, 2);
        run_burst(5, 1'b0);

        // Maximum burst length, all equal: max_cnt reaches 15.
        for (int i = 0; i < 15; i++) smp[i] = 4'd15;
        push_exp(15, 15, 15, 0, 15);
        run_burst(15, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_minmax_seq.md
Name: cmp_minmax_seq

Overview:
- Sequencer that time-shares one 4-bit magnitude comparator to find the maximum and minimum of a burst of operands.
- A host starts a burst of `len` samples. Samples arrive on a valid/ready handshake.
- Per sample, the block runs the shared comparator twice: once against the running max, once against the running min.
- Reports max, min, index of first max, and count of samples equal to the final max. Sits beside the comparator datapath as its controller.

Parameters:
- W, 4, operand width (comparator width)
- CNT_W, 4, burst-length/index width (max burst 2^CNT_W-1 = 15)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a burst when idle
- len  input  CNT_W  sample count, sampled on accepted start
- in_valid  input  1  sample present on in_data
- in_data  input  W  sample value
- in_ready  output  1  block accepts a sample this cycle
- busy  output  1  burst in progress (start accepted, done not yet pulsed)
- done  output  1  one-cycle pulse; results valid from this cycle until next accepted start
- max_val  output  W  largest sample
- min_val  output  W  smallest sample
- max_idx  output  CNT_W  0-based index of first occurrence of max_val
- max_cnt  output  CNT_W  number of samples equal to max_val

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE.
  - All outputs and internal registers are 0.
  - Applies in any state and aborts a burst mid-operation; no done pulse.
- Comparator encoding: Y[2]=A>B, Y[1]=A==B, Y[0]=A<B, exactly one bit set. The comparator is combinational; the controller registers decisions on the clock edge.
- FSM states: IDLE, WAIT, CMP_MAX, CMP_MIN, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 with len!=0: latch len, clear idx counter, go WAIT.
  - start=1 with len=0: go DONE with max_val=min_val=max_idx=max_cnt=0.
- WAIT:
  - in_ready=1, busy=1.
  - Transfer occurs when in_valid & in_ready; latch the sample into the operand register.
  - First sample (idx=0): max_val=min_val=sample, max_idx=0, max_cnt=1; skip the compares.
  - Sample idx==len-1: go DONE.
  - Otherwise: stay WAIT and increment idx.
  - Later samples (idx>0): go CMP_MAX.
- CMP_MAX (comparator A=operand, B=max_val):
  - gt: max_val=operand, max_idx=idx, max_cnt=1.
  - eq: max_cnt+=1.
  - lt: no change.
  - Go CMP_MIN.
- CMP_MIN (comparator A=operand, B=min_val):
  - lt: min_val=operand.
  - Otherwise no change.
  - If idx==len-1 go DONE; else increment idx and go WAIT.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Throughput: first sample takes 1 cycle; each later sample takes 3 cycles (WAIT, CMP_MAX, CMP_MIN).
- Latency from last transfer to done:
  - len=1: done on the next cycle.
  - Otherwise: done 3 cycles after the last transfer edge.
- in_ready is 0 in CMP_MAX and CMP_MIN; in_valid held high across those states causes no transfer.
- start is ignored while busy or in DONE.
- Results hold until the next accepted start, which clears them.
- Ties:
  - max_idx keeps the earliest index.
  - min_val is updated only on strict lt.
  - max_cnt saturates naturally, since len<=15 and max_cnt never exceeds len.
- Data stalls: in_valid low in WAIT stalls indefinitely with no timeout.

Decomposition:
- Shared package cmp_pkg:
  - State encoding localparams (IDLE=0, WAIT=1, CMP_MAX=2, CMP_MIN=3, DONE=4).
  - Comparator result bit positions (GT=2, EQ=1, LT=0).
  - W and CNT_W defaults.
- One sub-module, cmp_mag:
  - Parameterised-W combinational comparator (A, B → Y[2:0]).
  - Instantiated once; its A/B inputs are muxed by state.
- Everything else (FSM, registers, counters) lives in cmp_minmax_seq.

Test Plan:
- Reset mid-burst: start len=3, send 5, then assert rst → busy=0, in_ready=0, all outputs 0, no done; a subsequent burst works normally.
- Basic burst: len=4, samples 3,9,1,9 with in_valid always high → max_val=9, max_idx=1, max_cnt=2, min_val=1; done pulses exactly once, 3 cycles after the 4th transfer.
- Single sample: len=1, sample 7 → max=min=7, max_idx=0, max_cnt=1; done on the cycle after the transfer.
- len=0: start with len=0 → done 1 cycle later, all results 0, in_ready never high.
- Back-pressure and stalls: len=3, samples 15,0,15 with in_valid toggling randomly → in_ready never high in CMP states, exactly 3 transfers, max=15, max_idx=0, max_cnt=2, min=0.
- start during burst: pulse start (len=2) while busy with a len=3 burst → ignored; first burst's results and len are unaffected.
